// File: rtl/ram_hs_pkg.sv
// -----------------------------------------------------------------------------
// ram_hs_pkg
// Shared types, constants and helpers for the handshake RAM controller.
//   state_t     : controller FSM states (clear sweep / idle)
//   OP_READ/OP_WRITE : encoding of the wr_rd request bit
//   byte_parity : per-byte even parity of a data word (bit i covers byte i)
// Optional feature macro used by the RAM files: RAM_HS_PARITY_EN
// -----------------------------------------------------------------------------
package ram_hs_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // byte_parity works on the widest supported word; callers zero-extend
    // their data and keep the low DATA_W/8 bits (zero bytes have parity 0).
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_BE_W-1:0] byte_parity(input logic [MAX_DATA_W-1:0] data);
        logic [MAX_BE_W-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            p[i] = ^data[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_hs_array.sv
// -----------------------------------------------------------------------------
// ram_hs_array
// Single-port storage: byte-enable synchronous write and registered read on a
// shared address. With RAM_HS_PARITY_EN defined each byte carries an even
// parity bit and the read port flags a mismatch alongside the read data.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (read register only)
//   i_addr       : word address (caller keeps it < DEPTH when enabled)
//   i_we         : per-byte write enables
//   i_wdata      : write data
//   i_re         : read enable, loads o_rdata at the edge
//   o_rdata      : registered read data
//   o_par_err    : registered parity mismatch of the last read (0 if no parity)
// -----------------------------------------------------------------------------
module ram_hs_array
    import ram_hs_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 4,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BE_W-1:0]   i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_par_err
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the storage array has no reset branch; a reset loop over every
    // word does not map onto RAM macros, so the controller's clear sweep
    // defines the contents instead.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_we[b]) begin
                // NOTE: sequential state always uses non-blocking assignment so
                // every reader of r_mem sees the value from before this edge.
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

`ifdef RAM_HS_PARITY_EN
    logic [BE_W-1:0]     r_par [DEPTH];
    logic [MAX_BE_W-1:0] w_wpar;
    logic [MAX_BE_W-1:0] w_rpar;
    logic                r_par_err;

    assign w_wpar = byte_parity(MAX_DATA_W'(i_wdata));
    assign w_rpar = byte_parity(MAX_DATA_W'(r_mem[i_addr]));

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_we[b]) begin
                r_par[i_addr][b] <= w_wpar[b];
            end
        end
    end

    // Parity is rechecked on every byte of the word, not only enabled ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (i_re) begin
            r_par_err <= (w_rpar[BE_W-1:0] != r_par[i_addr]);
        end
    end

    assign o_par_err = r_par_err;
`else
    assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/ram_hs_ctrl.sv
// -----------------------------------------------------------------------------
// ram_hs_ctrl
// Single-port scratch RAM behind a valid/ready request bus. After reset, or on
// a clr request, a hardware sweep zeroes every word (busy high, ready low for
// DEPTH cycles). Reads have one cycle latency with a rd_valid strobe; requests
// to add >= DEPTH are flagged on err (writes dropped, reads return 0).
// Optional macro RAM_HS_PARITY_EN: per-byte even parity, checked on reads and
// reported on par_err (constant 0 when undefined).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   valid, ready    : request handshake (accepted when both high)
//   wr_rd           : 1 = write, 0 = read
//   add, be         : word address, byte enables (writes only)
//   writedata       : write data
//   clr             : single-cycle request to zero the array
//   readdata        : read data, held until the next accepted read
//   rd_valid        : one-cycle pulse, readdata is new
//   err             : one-cycle pulse, accepted request was out of range
//   busy            : clear sweep in progress
//   par_err         : parity mismatch pulse, aligned with rd_valid
// -----------------------------------------------------------------------------
module ram_hs_ctrl
    import ram_hs_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 4,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              wr_rd,
    input  logic [ADDR_W-1:0] add,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] writedata,
    input  logic              clr,
    output logic              ready,
    output logic [DATA_W-1:0] readdata,
    output logic              rd_valid,
    output logic              err,
    output logic              busy,
    output logic              par_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic                w_ready;
    logic                w_busy;

    logic                r_rd_valid;
    logic                r_err;
    logic                r_rd_oor;

    logic                w_accept;
    logic                w_is_write;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_arr_addr;
    logic [BE_W-1:0]     w_arr_we;
    logic [DATA_W-1:0]   w_arr_wdata;
    logic                w_arr_re;
    logic [DATA_W-1:0]   w_arr_rdata;
    logic                w_arr_par_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_ready       = 1'b0;
        w_busy        = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                w_busy        = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_IDLE: begin
                // clr wins over a same-cycle request: it is simply not accepted.
                w_ready = !clr;
                if (clr) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign ready = w_ready;
    assign busy  = w_busy;

    assign w_accept   = valid && w_ready;
    assign w_is_write = (wr_rd == OP_WRITE);
    assign w_in_range = ({1'b0, add} < DEPTH_L);

    // The sweep owns the single port while busy; requests are blocked then.
    assign w_arr_addr  = w_busy ? r_clr_cnt : add;
    assign w_arr_we    = w_busy ? '1 : ((w_accept && w_is_write && w_in_range) ? be : '0);
    assign w_arr_wdata = w_busy ? '0 : writedata;
    assign w_arr_re    = w_accept && !w_is_write && w_in_range;

    ram_hs_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (w_arr_addr),
        .i_we      (w_arr_we),
        .i_wdata   (w_arr_wdata),
        .i_re      (w_arr_re),
        .o_rdata   (w_arr_rdata),
        .o_par_err (w_arr_par_err)
    );

    // r_rd_oor remembers whether the last accepted read was out of range, so
    // readdata shows 0 for it and otherwise holds the array's read register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_valid <= w_accept && !w_is_write;
            r_err      <= w_accept && !w_in_range;
            if (w_accept && !w_is_write) begin
                r_rd_oor <= !w_in_range;
            end
        end
    end

    assign readdata = r_rd_oor ? '0 : w_arr_rdata;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;
    // The array reports 0 when parity storage is not built.
    assign par_err  = r_rd_valid && !r_rd_oor && w_arr_par_err;

endmodule

// File: tb/tb_ram_hs_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_hs_ctrl
// Directed bench for ram_hs_ctrl using three instances:
//   dut_a : DATA_W=8,  DEPTH=16 (main functional tests, parity under macro)
//   dut_b : DATA_W=32, DEPTH=16 (byte enables)
//   dut_c : DATA_W=8,  DEPTH=12 (out-of-range handling)
// Inputs are driven on the falling edge, outputs sampled on the next falling
// edge, i.e. half a cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_ram_hs_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // dut_a
    logic       a_valid, a_wr_rd, a_clr, a_ready, a_rd_valid, a_err, a_busy, a_par_err;
    logic [3:0] a_add;
    logic [0:0] a_be;
    logic [7:0] a_wdata, a_rdata;
    // dut_b
    logic        b_valid, b_wr_rd, b_clr, b_ready, b_rd_valid, b_err, b_busy, b_par_err;
    logic [3:0]  b_add;
    logic [3:0]  b_be;
    logic [31:0] b_wdata, b_rdata;
    // dut_c
    logic       c_valid, c_wr_rd, c_clr, c_ready, c_rd_valid, c_err, c_busy, c_par_err;
    logic [3:0] c_add;
    logic [0:0] c_be;
    logic [7:0] c_wdata, c_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] a_model [16];

    ram_hs_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst), .valid(a_valid), .wr_rd(a_wr_rd), .add(a_add), .be(a_be),
        .writedata(a_wdata), .clr(a_clr), .ready(a_ready), .readdata(a_rdata),
        .rd_valid(a_rd_valid), .err(a_err), .busy(a_busy), .par_err(a_par_err)
    );

    ram_hs_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .valid(b_valid), .wr_rd(b_wr_rd), .add(b_add), .be(b_be),
        .writedata(b_wdata), .clr(b_clr), .ready(b_ready), .readdata(b_rdata),
        .rd_valid(b_rd_valid), .err(b_err), .busy(b_busy), .par_err(b_par_err)
    );

    ram_hs_ctrl #(.DATA_W(8), .DEPTH(12), .ADDR_W(4)) dut_c (
        .clk(clk), .rst(rst), .valid(c_valid), .wr_rd(c_wr_rd), .add(c_add), .be(c_be),
        .writedata(c_wdata), .clr(c_clr), .ready(c_ready), .readdata(c_rdata),
        .rd_valid(c_rd_valid), .err(c_err), .busy(c_busy), .par_err(c_par_err)
    );

    // Counts busy cycles of each instance from the current falling edge until
    // every sweep is done (bounded), plus cycles where ready was high while busy.
    task automatic wait_sweep(output int n_a, output int n_b, output int n_c, output int rdy_bad);
        n_a = 0; n_b = 0; n_c = 0; rdy_bad = 0;
        for (int k = 0; k < 64 && (a_busy || b_busy || c_busy); k++) begin
            if (a_busy) n_a++;
            if (b_busy) n_b++;
            if (c_busy) n_c++;
            if (a_busy && a_ready) rdy_bad++;
            if (b_busy && b_ready) rdy_bad++;
            if (c_busy && c_ready) rdy_bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n_a, n_b, n_c, rb;
        rst = 1'b0;
        a_valid = 0; a_wr_rd = 0; a_add = '0; a_be = '0; a_wdata = '0; a_clr = 0;
        b_valid = 0; b_wr_rd = 0; b_add = '0; b_be = '0; b_wdata = '0; b_clr = 0;
        c_valid = 0; c_wr_rd = 0; c_add = '0; c_be = '0; c_wdata = '0; c_clr = 0;
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b1)     begin errors++; $display("FAIL reset_busy: got %b want 1", a_busy); end
        checks++; if (a_ready !== 1'b0)    begin errors++; $display("FAIL reset_ready: got %b want 0", a_ready); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", a_rd_valid); end
        checks++; if (a_err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", a_err); end
        checks++; if (a_par_err !== 1'b0)  begin errors++; $display("FAIL reset_par_err: got %b want 0", a_par_err); end
        checks++; if (a_rdata !== 8'h00)   begin errors++; $display("FAIL reset_readdata: got %h want 00", a_rdata); end

        // Release, let the sweep run a few cycles, then reset again mid-sweep.
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL midsweep_busy: got %b want 1", a_busy); end
        @(negedge clk);
        rst = 1'b1;
        wait_sweep(n_a, n_b, n_c, rb);
        checks++; if (n_a != 16) begin errors++; $display("FAIL sweep_len_a: got %0d want 16", n_a); end
        checks++; if (n_b != 16) begin errors++; $display("FAIL sweep_len_b: got %0d want 16", n_b); end
        checks++; if (n_c != 12) begin errors++; $display("FAIL sweep_len_c: got %0d want 12", n_c); end
        checks++; if (rb != 0)   begin errors++; $display("FAIL sweep_ready_low: got %0d ready-while-busy cycles want 0", rb); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL post_sweep_ready_a: got %b want 1", a_ready); end
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL post_sweep_ready_c: got %b want 1", c_ready); end
        for (int i = 0; i < 16; i++) a_model[i] = 8'h00;
    endtask

    // Reads addresses 0..15 of dut_a back-to-back against a_model.
    task automatic test_read_all(input string tag);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                checks++; if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL %s_rd_valid[%0d]: got %b want 1", tag, i-1, a_rd_valid); end
                checks++; if (a_rdata !== a_model[i-1]) begin errors++; $display("FAIL %s_readdata[%0d]: got %h want %h", tag, i-1, a_rdata, a_model[i-1]); end
                checks++; if (a_par_err !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL %s_flags[%0d]: got par_err=%b err=%b want 0 0", tag, i-1, a_par_err, a_err); end
            end
            if (i < 16) begin
                a_valid = 1'b1; a_wr_rd = 1'b0; a_add = i[3:0];
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL %s_rd_valid_end: got %b want 0", tag, a_rd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tbl [16];
        int rv_seen;
        tbl = '{8'h3C, 8'hA5, 8'h01, 8'hFE, 8'h7E, 8'h42, 8'h99, 8'hC3,
                8'h10, 8'h5A, 8'hEF, 8'h08, 8'hB7, 8'h64, 8'hD2, 8'h2B};
        rv_seen = 0;
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b1; a_wr_rd = 1'b1; a_add = i[3:0]; a_be = 1'b1; a_wdata = tbl[i];
            a_model[i] = tbl[i];
            @(negedge clk);
            if (a_rd_valid) rv_seen++;
        end
        a_valid = 1'b0;
        checks++; if (rv_seen != 0) begin errors++; $display("FAIL write_no_rd_valid: got %0d pulses want 0", rv_seen); end
        test_read_all("b2b");
    endtask

    task automatic test_byte_enable();
        b_valid = 1'b1; b_wr_rd = 1'b1; b_add = 4'd3; b_be = 4'hF; b_wdata = 32'hAABBCCDD;
        @(negedge clk);
        b_be = 4'b0101; b_wdata = 32'h11223344;
        @(negedge clk);
        b_wr_rd = 1'b0;
        @(negedge clk);
        b_valid = 1'b0;
        checks++; if (b_rd_valid !== 1'b1) begin errors++; $display("FAIL be_rd_valid: got %b want 1", b_rd_valid); end
        checks++; if (b_rdata !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge: got %h want aa22cc44", b_rdata); end
        @(negedge clk);
        checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL be_rd_valid_pulse: got %b want 0", b_rd_valid); end
        checks++; if (b_rdata !== 32'hAA22CC44) begin errors++; $display("FAIL be_hold: got %h want aa22cc44", b_rdata); end
        // be = 0 must leave the word untouched.
        b_valid = 1'b1; b_wr_rd = 1'b1; b_be = 4'h0; b_wdata = 32'h00000000;
        @(negedge clk);
        b_wr_rd = 1'b0;
        @(negedge clk);
        b_valid = 1'b0;
        checks++; if (b_rdata !== 32'hAA22CC44) begin errors++; $display("FAIL be_zero_noop: got %h want aa22cc44", b_rdata); end
    endtask

    task automatic test_clear_request();
        int n_a, n_b, n_c, rb;
        a_clr = 1'b1; a_valid = 1'b1; a_wr_rd = 1'b1; a_add = 4'd5; a_be = 1'b1; a_wdata = 8'hFF;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL clr_blocks_ready: got %b want 0", a_ready); end
        @(negedge clk);
        a_clr = 1'b0; a_valid = 1'b0;
        wait_sweep(n_a, n_b, n_c, rb);
        checks++; if (n_a != 16) begin errors++; $display("FAIL clr_sweep_len: got %0d want 16", n_a); end
        checks++; if (rb != 0)   begin errors++; $display("FAIL clr_ready_low: got %0d ready-while-busy cycles want 0", rb); end
        for (int i = 0; i < 16; i++) a_model[i] = 8'h00;
        test_read_all("clr");
    endtask

    task automatic test_out_of_range();
        c_valid = 1'b1; c_wr_rd = 1'b1; c_add = 4'd11; c_be = 1'b1; c_wdata = 8'h77;
        @(negedge clk);
        checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL oor_inrange_wr_err: got %b want 0", c_err); end
        c_add = 4'd13; c_wdata = 8'h5A;
        @(negedge clk);
        c_valid = 1'b0;
        checks++; if (c_err !== 1'b1)      begin errors++; $display("FAIL oor_wr_err: got %b want 1", c_err); end
        checks++; if (c_rd_valid !== 1'b0) begin errors++; $display("FAIL oor_wr_rd_valid: got %b want 0", c_rd_valid); end
        @(negedge clk);
        checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b want 0", c_err); end
        c_valid = 1'b1; c_wr_rd = 1'b0; c_add = 4'd11;
        @(negedge clk);
        checks++; if (c_rdata !== 8'h77) begin errors++; $display("FAIL oor_pre_read: got %h want 77", c_rdata); end
        c_add = 4'd13;
        @(negedge clk);
        checks++; if (c_rdata !== 8'h00 || c_rd_valid !== 1'b1 || c_err !== 1'b1)
            begin errors++; $display("FAIL oor_read: got data=%h rd_valid=%b err=%b want 00 1 1", c_rdata, c_rd_valid, c_err); end
        c_add = 4'd11;
        @(negedge clk);
        checks++; if (c_rdata !== 8'h77 || c_err !== 1'b0)
            begin errors++; $display("FAIL oor_read_11: got data=%h err=%b want 77 0", c_rdata, c_err); end
        c_add = 4'd1;
        @(negedge clk);
        checks++; if (c_rdata !== 8'h00) begin errors++; $display("FAIL oor_no_alias_1: got %h want 00", c_rdata); end
        c_add = 4'd5;
        @(negedge clk);
        c_valid = 1'b0;
        checks++; if (c_rdata !== 8'h00) begin errors++; $display("FAIL oor_no_alias_5: got %h want 00", c_rdata); end
    endtask

    task automatic test_parity();
`ifdef RAM_HS_PARITY_EN
        a_valid = 1'b1; a_wr_rd = 1'b1; a_add = 4'd2; a_be = 1'b1; a_wdata = 8'h0F;
        @(negedge clk);
        a_valid = 1'b0;
        force dut_a.u_array.r_mem[2] = 8'h0E;
        a_valid = 1'b1; a_wr_rd = 1'b0; a_add = 4'd2;
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_rd_valid !== 1'b1 || a_par_err !== 1'b1)
            begin errors++; $display("FAIL parity_detect: got rd_valid=%b par_err=%b want 1 1", a_rd_valid, a_par_err); end
        release dut_a.u_array.r_mem[2];
        a_valid = 1'b1; a_wr_rd = 1'b0; a_add = 4'd4;
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_rd_valid !== 1'b1 || a_par_err !== 1'b0)
            begin errors++; $display("FAIL parity_clean: got rd_valid=%b par_err=%b want 1 0", a_rd_valid, a_par_err); end
`else
        a_valid = 1'b1; a_wr_rd = 1'b0; a_add = 4'd2;
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_par_err !== 1'b0) begin errors++; $display("FAIL parity_off: got %b want 0", a_par_err); end
`endif
    endtask

    task automatic test_reset_mid_txn();
        int n_a, n_b, n_c, rb;
        a_valid = 1'b1; a_wr_rd = 1'b0; a_add = 4'd0;
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL midtxn_rd_valid: got %b want 1", a_rd_valid); end
        rst = 1'b0;
        #1;
        checks++; if (a_rd_valid !== 1'b0 || a_busy !== 1'b1)
            begin errors++; $display("FAIL midtxn_reset: got rd_valid=%b busy=%b want 0 1", a_rd_valid, a_busy); end
        @(negedge clk);
        rst = 1'b1;
        wait_sweep(n_a, n_b, n_c, rb);
        checks++; if (n_a != 16) begin errors++; $display("FAIL midtxn_sweep_len: got %0d want 16", n_a); end
    endtask

    initial begin
        test_reset();
        test_read_all("reset");
        test_back_to_back();
        test_byte_enable();
        test_clear_request();
        test_out_of_range();
        test_parity();
        test_reset_mid_txn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
